// File: rtl/bos_timing_ctrl.sv
// BOS analog-video timing sequencer: CCD pixel/line/frame strobes,
// DAC sample FIFO pacing and capture write-enable.
module bos_timing_ctrl #(
    parameter int PIX_W  = 12,
    parameter int LINE_W = 12
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       cfg_wr,
    input  logic [2:0] cfg_addr,
    input  logic [7:0] cfg_data,
    input  logic       start,
    input  logic       stop,
    input  logic       smp_empty,
    output logic       smp_rdreq,
    output logic       cap_en,
    output logic       clk_fpga,
    output logic       shp_fpga,
    output logic       shd_fpga,
    output logic       hd_fpga,
    output logic       vd_fpga,
    output logic       clpob_fpga,
    output logic       clpdm_fpga,
    output logic       pblk_fpga,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun,
    output logic       cfg_err
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, STOPPING} state_t;

    state_t            state;
    logic [PIX_W-1:0]  ppl;
    logic [PIX_W-1:0]  pix;
    logic [LINE_W-1:0] lpf;
    logic [LINE_W-1:0] line;
    logic [7:0]        hblank;
    logic [7:0]        clpob_start;
    logic [7:0]        clpob_len;
    logic [7:0]        frames;
    logic [7:0]        fcnt;
    logic [2:0]        phase;

    logic [PIX_W:0] pix_x;
    logic [PIX_W:0] hb_x;
    logic [PIX_W:0] cs_x;
    logic [PIX_W:0] ce_x;
    logic [7:0]     fcnt_nx;
    logic           cfg_ok;
    logic           last_pix;
    logic           last_line;
    logic           last_pos;
    logic           active;
    logic           running;
    logic           final_frame;
    logic           sample_slot;

    assign pix_x       = {1'b0, pix};
    assign hb_x        = (PIX_W+1)'(hblank);
    assign cs_x        = (PIX_W+1)'(clpob_start);
    assign ce_x        = cs_x + (PIX_W+1)'(clpob_len);
    assign cfg_ok      = (ppl != '0) && (lpf != '0) && (hb_x < {1'b0, ppl});
    assign last_pix    = (pix == ppl - PIX_W'(1));
    assign last_line   = (line == lpf - LINE_W'(1));
    assign last_pos    = (phase == 3'd7) && last_pix && last_line;
    assign active      = (pix_x >= hb_x);
    assign running     = (state == RUN) || (state == STOPPING);
    assign fcnt_nx     = (fcnt == 8'hFF) ? fcnt : fcnt + 8'd1;
    assign final_frame = (frames != 8'd0) && (fcnt_nx >= frames);
    assign sample_slot = running && active && (phase == 3'd7);

    // Geometry registers, writable only while the sequencer is idle
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            ppl         <= PIX_W'(16);
            lpf         <= LINE_W'(4);
            hblank      <= 8'd2;
            clpob_start <= 8'd0;
            clpob_len   <= 8'd0;
            frames      <= 8'd1;
        end else if (cfg_wr && (state == IDLE)) begin
            unique case (cfg_addr)
                3'd0: ppl         <= {ppl[PIX_W-1:8], cfg_data};
                3'd1: ppl         <= PIX_W'({cfg_data, ppl[7:0]});
                3'd2: lpf         <= {lpf[LINE_W-1:8], cfg_data};
                3'd3: lpf         <= LINE_W'({cfg_data, lpf[7:0]});
                3'd4: hblank      <= cfg_data;
                3'd5: clpob_start <= cfg_data;
                3'd6: clpob_len   <= cfg_data;
                3'd7: frames      <= cfg_data;
            endcase
        end
    end

    // Run-control FSM, position counters and registered strobe decodes
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            phase      <= '0;
            pix        <= '0;
            line       <= '0;
            fcnt       <= '0;
            clk_fpga   <= 1'b0;
            shp_fpga   <= 1'b1;
            shd_fpga   <= 1'b1;
            hd_fpga    <= 1'b0;
            vd_fpga    <= 1'b0;
            clpob_fpga <= 1'b0;
            clpdm_fpga <= 1'b0;
            pblk_fpga  <= 1'b0;
            cap_en     <= 1'b0;
            smp_rdreq  <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !stop) begin
                        if (cfg_ok) begin
                            state    <= ARM;
                            busy     <= 1'b1;
                            fcnt     <= '0;
                            underrun <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ARM: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!smp_empty) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (last_pos && (stop || final_frame)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (stop) begin
                        state <= STOPPING;
                    end
                end
                STOPPING: begin
                    if (last_pos) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase

            if (running) begin
                phase <= phase + 3'd1;
                if (phase == 3'd7) begin
                    if (last_pix) begin
                        pix  <= '0;
                        line <= last_line ? '0 : line + LINE_W'(1);
                    end else begin
                        pix <= pix + PIX_W'(1);
                    end
                end
                if (last_pos) begin
                    fcnt <= fcnt_nx;
                end
                if (sample_slot && smp_empty) begin
                    underrun <= 1'b1;
                end
            end

            clk_fpga   <= running && (phase < 3'd4);
            shp_fpga   <= !(running && (phase == 3'd1));
            shd_fpga   <= !(running && (phase == 3'd5));
            hd_fpga    <= running && (pix == '0);
            vd_fpga    <= running && (line == '0);
            clpdm_fpga <= running && (line == '0);
            pblk_fpga  <= running && !active;
            clpob_fpga <= running && (pix_x >= cs_x) && (pix_x < ce_x);
            cap_en     <= running && active;
            smp_rdreq  <= sample_slot && !smp_empty;
            frame_done <= running && last_pos;
        end
    end

endmodule

// File: tb/tb_bos_timing_ctrl.sv
// Self-checking bench for bos_timing_ctrl: config-acceptance table,
// directed frame runs and randomized runs against a position model.
module tb_bos_timing_ctrl;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       cfg_wr;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       start;
    logic       stop;
    logic       smp_empty;
    logic       smp_rdreq;
    logic       cap_en;
    logic       clk_fpga;
    logic       shp_fpga;
    logic       shd_fpga;
    logic       hd_fpga;
    logic       vd_fpga;
    logic       clpob_fpga;
    logic       clpdm_fpga;
    logic       pblk_fpga;
    logic       busy;
    logic       frame_done;
    logic       underrun;
    logic       cfg_err;

    int n_chk = 0;
    int n_bad = 0;

    int m_ppl;
    int m_lpf;
    int m_hb;
    int m_cs;
    int m_cl;
    int m_frames;

    bos_timing_ctrl #(.PIX_W(12), .LINE_W(12)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .start      (start),
        .stop       (stop),
        .smp_empty  (smp_empty),
        .smp_rdreq  (smp_rdreq),
        .cap_en     (cap_en),
        .clk_fpga   (clk_fpga),
        .shp_fpga   (shp_fpga),
        .shd_fpga   (shd_fpga),
        .hd_fpga    (hd_fpga),
        .vd_fpga    (vd_fpga),
        .clpob_fpga (clpob_fpga),
        .clpdm_fpga (clpdm_fpga),
        .pblk_fpga  (pblk_fpga),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun),
        .cfg_err    (cfg_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [7:0] pl;
        logic [7:0] ph;
        logic [7:0] ll;
        logic [7:0] lh;
        logic [7:0] hb;
        bit         st;
        bit         sp;
        bit         err;
        bit         bsy;
    } vec_t;

    vec_t vecs[12];

    // {clk shp shd hd vd clpob clpdm pblk cap rdreq fdone busy underrun cfg_err}
    function automatic logic [13:0] obs();
        return {clk_fpga, shp_fpga, shd_fpga, hd_fpga, vd_fpga, clpob_fpga,
                clpdm_fpga, pblk_fpga, cap_en, smp_rdreq, frame_done,
                busy, underrun, cfg_err};
    endfunction

    function automatic logic [13:0] idle_v(input bit b, input bit u, input bit e);
        return {3'b011, 8'b0, b, u, e};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [13:0] got, input logic [13:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%b want=%b", nm, got, want);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cfg_wr   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ppl = 16; m_lpf = 4; m_hb = 2;
        m_cs = 0; m_cl = 0; m_frames = 1;
    endtask

    task automatic set_cfg(input int p, input int l, input int h,
                           input int cs, input int cl, input int fr);
        wr(3'd0, 8'(p));
        wr(3'd1, 8'(p >> 8));
        wr(3'd2, 8'(l));
        wr(3'd3, 8'(l >> 8));
        wr(3'd4, 8'(h));
        wr(3'd5, 8'(cs));
        wr(3'd6, 8'(cl));
        wr(3'd7, 8'(fr));
        m_ppl = p; m_lpf = l; m_hb = h;
        m_cs = cs; m_cl = cl; m_frames = fr;
    endtask

    // Start a run and compare every output cycle against the position model.
    // emode: 0 FIFO never empty, 1 random empty, 2 empty from position epos on.
    // spos: position during which stop is asserted (-1 = never).
    task automatic run_check(input string nm, input int emode, input int epos,
                             input int spos, output int n_rd, output int n_fd,
                             output int n_vd, output int n_cap);
        int len;
        int nf;
        int total;
        int ph;
        int px;
        int ln;
        bit e;
        bit act;
        bit ur;
        logic [13:0] w;
        len = 8 * m_ppl * m_lpf;
        nf = (spos >= 0) ? spos / len + 1 : 1000000;
        if (m_frames != 0 && m_frames < nf) nf = m_frames;
        total = nf * len;
        n_rd = 0; n_fd = 0; n_vd = 0; n_cap = 0;
        smp_empty = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({nm, "_arm"}, obs(), idle_v(1'b1, 1'b0, 1'b0));
        tick();
        check({nm, "_arm2"}, obs(), idle_v(1'b1, 1'b0, 1'b0));
        ur = 1'b0;
        for (int k = 0; k < total; k++) begin
            e = (emode == 1) ? ($urandom_range(0, 7) == 0) :
                (emode == 2) ? (k >= epos) : 1'b0;
            smp_empty = e;
            stop = (k == spos);
            tick();
            stop = 1'b0;
            ph  = k % 8;
            px  = (k / 8) % m_ppl;
            ln  = (k / (8 * m_ppl)) % m_lpf;
            act = (px >= m_hb);
            if (act && ph == 7 && e) ur = 1'b1;
            w = {ph < 4, ph != 1, ph != 5, px == 0, ln == 0,
                 (px >= m_cs) && (px < m_cs + m_cl), ln == 0, !act, act,
                 act && ph == 7 && !e, (k % len) == len - 1,
                 k != total - 1, ur, 1'b0};
            check(nm, obs(), w);
            n_rd  += int'(smp_rdreq);
            n_fd  += int'(frame_done);
            n_vd  += int'(vd_fpga);
            n_cap += int'(cap_en);
        end
        smp_empty = 1'b0;
        tick();
        check({nm, "_end"}, obs(), idle_v(1'b0, ur, 1'b0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd;
        int fd;
        int vd;
        int cp;
        int p;
        int l;
        int fr;
        int sp;
        int len;
        rst = 1'b1;
        cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; stop = 1'b0; smp_empty = 1'b1;
        vecs[0]  = '{8'd0,   8'h00, 8'd4, 8'h00, 8'd2,   1, 0, 1, 0};
        vecs[1]  = '{8'd16,  8'h00, 8'd4, 8'h00, 8'd16,  1, 0, 1, 0};
        vecs[2]  = '{8'd16,  8'h00, 8'd0, 8'h00, 8'd2,   1, 0, 1, 0};
        vecs[3]  = '{8'd16,  8'h00, 8'd4, 8'h00, 8'd15,  1, 0, 0, 1};
        vecs[4]  = '{8'd0,   8'h00, 8'd4, 8'h00, 8'd2,   1, 1, 0, 0};
        vecs[5]  = '{8'd16,  8'h00, 8'd4, 8'h00, 8'd2,   1, 1, 0, 0};
        vecs[6]  = '{8'd0,   8'h10, 8'd4, 8'h00, 8'd2,   1, 0, 1, 0};
        vecs[7]  = '{8'd0,   8'h01, 8'd0, 8'h10, 8'd255, 1, 0, 1, 0};
        vecs[8]  = '{8'd0,   8'h01, 8'd1, 8'h00, 8'd255, 1, 0, 0, 1};
        vecs[9]  = '{8'd1,   8'h00, 8'd1, 8'h00, 8'd0,   1, 0, 0, 1};
        vecs[10] = '{8'd1,   8'h00, 8'd1, 8'h00, 8'd1,   1, 0, 1, 0};
        vecs[11] = '{8'd16,  8'h00, 8'd4, 8'h00, 8'd2,   0, 1, 0, 0};
        #12;
        rst = 1'b0;
        #1;
        check("reset_idle", obs(), idle_v(1'b0, 1'b0, 1'b0));
        do_reset();

        for (int i = 0; i < 12; i++) begin
            wr(3'd0, vecs[i].pl);
            wr(3'd1, vecs[i].ph);
            wr(3'd2, vecs[i].ll);
            wr(3'd3, vecs[i].lh);
            wr(3'd4, vecs[i].hb);
            smp_empty = 1'b1;
            start = vecs[i].st;
            stop  = vecs[i].sp;
            tick();
            start = 1'b0;
            stop  = 1'b0;
            check($sformatf("vec%0d", i), obs(),
                  idle_v(vecs[i].bsy, 1'b0, vecs[i].err));
            tick();
            check($sformatf("vec%0d_pulse", i), obs(),
                  idle_v(vecs[i].bsy, 1'b0, 1'b0));
            if (vecs[i].bsy) begin
                stop = 1'b1;
                tick();
                stop = 1'b0;
                check($sformatf("vec%0d_armstop", i), obs(),
                      idle_v(1'b0, 1'b0, 1'b0));
            end
        end

        do_reset();
        smp_empty = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_hold", obs(), idle_v(1'b1, 1'b0, 1'b0));
        wr(3'd4, 8'd9);
        wr(3'd0, 8'd5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("busy_stop", obs(), idle_v(1'b0, 1'b0, 1'b0));

        run_check("dflt", 0, 0, -1, rd, fd, vd, cp);
        check_int("dflt_rdreq", rd, 56);
        check_int("dflt_fdone", fd, 1);
        check_int("dflt_vd", vd, 128);

        set_cfg(10, 4, 3, 4, 2, 1);
        run_check("geom", 0, 0, -1, rd, fd, vd, cp);
        check_int("geom_cap", cp, 56 * 4);
        check_int("geom_rdreq", rd, 7 * 4);

        set_cfg(16, 4, 2, 0, 0, 1);
        run_check("undr", 2, 16, -1, rd, fd, vd, cp);
        check_int("undr_rdreq", rd, 0);
        repeat (3) tick();
        check("undr_sticky", obs(), idle_v(1'b0, 1'b1, 1'b0));
        run_check("undr_clr", 0, 0, -1, rd, fd, vd, cp);

        set_cfg(16, 4, 2, 0, 0, 0);
        run_check("cont", 0, 0, 2 * 512 + 2 * 128 + 64, rd, fd, vd, cp);
        check_int("cont_fdone", fd, 3);
        check_int("cont_rdreq", rd, 3 * 56);

        set_cfg(10, 4, 2, 0, 0, 1);
        smp_empty = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (200) tick();
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", obs(), idle_v(1'b0, 1'b0, 1'b0));
        tick();
        rst = 1'b0;
        m_ppl = 16; m_lpf = 4; m_hb = 2;
        m_cs = 0; m_cl = 0; m_frames = 1;
        run_check("post_rst", 0, 0, -1, rd, fd, vd, cp);
        check_int("post_rst_fdone", fd, 1);

        for (int r = 0; r < 6; r++) begin
            p  = $urandom_range(1, 20);
            l  = $urandom_range(1, 4);
            fr = $urandom_range(0, 3);
            set_cfg(p, l, $urandom_range(0, p - 1), $urandom_range(0, p),
                    $urandom_range(0, 6), fr);
            len = 8 * p * l;
            if (fr == 0) sp = $urandom_range(0, 2 * len - 1);
            else if ($urandom_range(0, 1) == 1) sp = $urandom_range(0, fr * len - 1);
            else sp = -1;
            run_check($sformatf("rnd%0d", r), 1, 0, sp, rd, fd, vd, cp);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
